// File: rtl/irq_controller_if.sv
// Register-slot bus between the mmio_controller and the interrupt controller:
// register select, write strobe, chip enable, write data and read data.
interface irq_controller_if;
    logic [2:0] rs;
    logic       we;
    logic       en;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (
        output rs,
        output we,
        output en,
        output din,
        input  dout
    );

    modport slave (
        input  rs,
        input  we,
        input  en,
        input  din,
        output dout
    );
endinterface

// File: rtl/irq_controller.sv
// irq_controller: memory-mapped interrupt controller for the 65C02 IRQ line.
// Latches edge events or follows level requests per source, masks them,
// prioritises the lowest index and reports it through the VEC register.
// A read of VEC acknowledges the winning interrupt.
// Optional feature macro: IRQC_SYNC_EN adds a two-flop synchronizer on every
// src_irq bit so asynchronous pins can be connected directly.
module irq_controller #(
    parameter int N_SRC = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    irq_controller_if.slave      bus,
    input  logic [N_SRC-1:0]     src_irq,
    output logic                 irq
);

    localparam logic [2:0] RS_PEND  = 3'd0;
    localparam logic [2:0] RS_MASK  = 3'd1;
    localparam logic [2:0] RS_MODE  = 3'd2;
    localparam logic [2:0] RS_VEC   = 3'd3;
    localparam logic [2:0] RS_SWSET = 3'd4;
    localparam logic [2:0] RS_COUNT = 3'd5;

    logic [N_SRC-1:0] src_s;
    logic [N_SRC-1:0] src_p_q;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] mode_q, mode_d;
    logic [7:0]       count_q, count_d;
    logic             irq_q, irq_d;

    logic [N_SRC-1:0] din_n;
    logic [N_SRC-1:0] active;
    logic             any_active;
    logic [2:0]       win_idx;
    logic             ack;
    logic             wr_pend, wr_mask, wr_mode, wr_swset, wr_count;
    logic [N_SRC-1:0] edge_set;
    logic [N_SRC-1:0] edge_clr;
    logic [N_SRC-1:0] mode_chg;

    // Lowest set index wins; bit 0 has the highest priority.
    function automatic logic [2:0] lowest_idx(input logic [N_SRC-1:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Zero-extend an N_SRC-wide register to the 8-bit read bus.
    function automatic logic [7:0] ext8(input logic [N_SRC-1:0] v);
        logic [7:0] r;
        r = '0;
        r[N_SRC-1:0] = v;
        return r;
    endfunction

`ifdef IRQC_SYNC_EN
    logic [N_SRC-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer for asynchronous source pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= src_irq;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = src_irq;
`endif

    assign din_n      = bus.din[N_SRC-1:0];
    assign active     = pend_q & mask_q;
    assign any_active = |active;
    assign win_idx    = lowest_idx(active);

    assign wr_pend  = bus.en & bus.we & (bus.rs == RS_PEND);
    assign wr_mask  = bus.en & bus.we & (bus.rs == RS_MASK);
    assign wr_mode  = bus.en & bus.we & (bus.rs == RS_MODE);
    assign wr_swset = bus.en & bus.we & (bus.rs == RS_SWSET);
    assign wr_count = bus.en & bus.we & (bus.rs == RS_COUNT);
    // Only a read of VEC with something to report counts as an acknowledge.
    assign ack      = bus.en & ~bus.we & (bus.rs == RS_VEC) & any_active;

    // Next-state for pending, mask, mode, count and the registered irq.
    always_comb begin
        edge_set = (src_s & ~src_p_q) | (wr_swset ? din_n : '0);
        edge_clr = (wr_pend ? din_n : '0) | (ack ? (N_SRC'(1) << win_idx) : '0);
        // A mode flip in either direction drops whatever was latched, so an
        // already-high source switched to edge mode raises no event.
        mode_chg = wr_mode ? (din_n ^ mode_q) : '0;
        // Edge bits: set wins over clear. Level bits simply follow the source.
        pend_d   = ((mode_q & (edge_set | (pend_q & ~edge_clr))) |
                    (~mode_q & src_s)) & ~mode_chg;
        mask_d   = wr_mask ? din_n : mask_q;
        mode_d   = wr_mode ? din_n : mode_q;
        count_d  = count_q;
        if (wr_count) begin
            count_d = 8'h00;
        end else if (ack) begin
            count_d = count_q + 8'h01;
        end
        irq_d    = any_active;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_p_q <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            mode_q  <= '0;
            count_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            src_p_q <= src_s;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            irq_q   <= irq_d;
        end
    end

    // Read mux; VEC shows the pre-acknowledge winner in the access cycle.
    always_comb begin
        bus.dout = 8'h00;
        case (bus.rs)
            RS_PEND:  bus.dout = ext8(pend_q);
            RS_MASK:  bus.dout = ext8(mask_q);
            RS_MODE:  bus.dout = ext8(mode_q);
            RS_VEC:   bus.dout = any_active ? {1'b1, 4'b0000, win_idx} : 8'h00;
            RS_COUNT: bus.dout = count_q;
            default:  bus.dout = 8'h00;
        endcase
    end

    assign irq = irq_q;

endmodule
